// File: rtl/simplez_io_uart_if.sv
// Simplez memory-bus slice seen by the I/O peripheral: address, strobes, data and chip select.
interface simplez_io_uart_if #(
    parameter int DATAW = 12,
    parameter int ADDRW = 9
);
    logic [ADDRW-1:0] addr;
    logic             wr;
    logic             rd;
    logic [DATAW-1:0] data_in;
    logic [DATAW-1:0] data_out;
    logic             cs;

    modport master (output addr, wr, rd, data_in, input data_out, cs);
    modport slave  (input addr, wr, rd, data_in, output data_out, cs);
endinterface

// File: rtl/simplez_io_uart.sv
// Simplez memory-mapped I/O: 4-bit LED register plus an 8N1 serial transmitter
// with a status word and a readback of the last byte sent.
module simplez_io_uart #(
    parameter int DATAW     = 12,
    parameter int ADDRW     = 9,
    parameter int BAUDDIV   = 104,
    parameter int ADDR_LEDS = 507,
    parameter int ADDR_TXST = 508,
    parameter int ADDR_TXD  = 509
) (
    input  logic             clk,
    input  logic             rstn,
    simplez_io_uart_if.slave bus,
    output logic [3:0]       leds,
    output logic             tx
);
    localparam int CNTW = (BAUDDIV > 1) ? $clog2(BAUDDIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BAUDDIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [ADDRW-1:0] A_LEDS = ADDRW'(ADDR_LEDS);
    localparam logic [ADDRW-1:0] A_TXST = ADDRW'(ADDR_TXST);
    localparam logic [ADDRW-1:0] A_TXD  = ADDRW'(ADDR_TXD);

    logic [1:0]       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       txbuf_q, txbuf_d;
    logic [3:0]       leds_q, leds_d;
    logic             ready_q, ready_d;
    logic             tx_q, tx_d;
    logic [DATAW-1:0] dout_q, dout_d;

    logic sel_leds, sel_txst, sel_txd;
    logic bit_done, frame_done, tx_accept;
    logic unused_data_hi;

    assign sel_leds = (bus.addr == A_LEDS);
    assign sel_txst = (bus.addr == A_TXST);
    assign sel_txd  = (bus.addr == A_TXD);
    assign bus.cs   = sel_leds | sel_txst | sel_txd;

    assign bit_done   = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
    assign frame_done = bit_done && (state_q == S_STOP);
    // Accepting in the stop-completion cycle lets frames run back to back.
    assign tx_accept  = bus.wr && sel_txd && (ready_q || frame_done);

    assign unused_data_hi = ^bus.data_in[DATAW-1:8];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txbuf_d = txbuf_q;
        leds_d  = leds_q;
        ready_d = ready_q;
        tx_d    = tx_q;
        dout_d  = dout_q;

        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNTW'(1);
        end

        if (bit_done) begin
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                    bit_d   = 3'd0;
                end
                S_DATA: begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (bus.wr && sel_leds) begin
            leds_d = bus.data_in[3:0];
        end

        if (tx_accept) begin
            txbuf_d = bus.data_in[7:0];
            shreg_d = bus.data_in[7:0];
            ready_d = 1'b0;
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = 3'd0;
            tx_d    = 1'b0;
        end

        // Reads see the pre-write register values of this cycle.
        if (bus.rd) begin
            if (sel_leds)      dout_d = DATAW'(leds_q);
            else if (sel_txst) dout_d = DATAW'(ready_q);
            else if (sel_txd)  dout_d = DATAW'(txbuf_q);
            else               dout_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            txbuf_q <= 8'd0;
            leds_q  <= 4'd0;
            ready_q <= 1'b1;
            tx_q    <= 1'b1;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txbuf_q <= txbuf_d;
            leds_q  <= leds_d;
            ready_q <= ready_d;
            tx_q    <= tx_d;
            dout_q  <= dout_d;
        end
    end

    assign leds         = leds_q;
    assign tx           = tx_q;
    assign bus.data_out = dout_q;
endmodule
